seconds: RTL
============

SECONDS -- requirements
Module: seconds

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, clk cycles per second; legal range 2..2^32-1.
REQ-002 clk  input  1  system clock; all state updates on rising edge only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 display  input  1  mode select: 0 = run (timekeeping), 1 = setup (manual edit).
REQ-005 setup_second  input  1  edit enable, active-low: 0 = seconds field selected for edit in setup mode.
REQ-006 inc_dec_sec  input  1  edit direction: 1 = increment, 0 = decrement.
REQ-007 tick  input  1  single-cycle edit strobe from button logic; one step per high cycle.
REQ-008 second  output  6  current seconds value, registered, range 0..59.
REQ-009 done_second  output  1  registered one-cycle carry pulse to the minutes block (its done_sec input).

Function
REQ-010 Internal prescaler counter, width $clog2(CLK_FREQ), counts 0..CLK_FREQ-1 while display=0; sec_strobe asserts combinationally when count == CLK_FREQ-1; count then wraps to 0.
REQ-011 While display=1 the prescaler is held at 0; on return to display=0, the first sec_strobe occurs exactly CLK_FREQ cycles later.
REQ-012 Run mode (display=0), sec_strobe=1: second 0..58 -> second+1; second 59 -> 0.
REQ-013 Run mode, sec_strobe=0: second holds.
REQ-014 done_second = 1 for exactly the one cycle in which second first reads 0 after a run-mode 59->0 wrap (registered at the same edge as the wrap); 0 in all other cycles.
REQ-015 Setup mode (display=1), setup_second=0, tick=1: inc_dec_sec=1 -> 59 wraps to 0, else +1; inc_dec_sec=0 -> 0 wraps to 59, else -1.
REQ-016 Setup mode with setup_second=1 or tick=0: second holds.
REQ-017 Setup-mode wraps never assert done_second.
REQ-018 tick is ignored in run mode; sec_strobe is ignored in setup mode (prescaler is held at 0, so none occurs).
REQ-019 Defensive: any update event (sec_strobe in run mode, or a qualified tick in setup mode) with second in 60..63 loads 0, with no done_second.
REQ-020 Mode switch takes effect at the edge where display is sampled; a sec_strobe coinciding with display=1 is discarded.
REQ-021 Arithmetic is 6-bit unsigned; no value outside 0..59 is produced from legal state.

Reset
REQ-022 rst=1 at a clk edge: second=0, done_second=0, prescaler=0; overrides all other inputs.
REQ-023 Reset asserted mid-count or mid-edit discards partial prescaler progress; the first sec_strobe after release occurs CLK_FREQ cycles after the first edge with rst=0 and display=0.

Structure
REQ-024 Shared package clock_pkg holds SEC_MAX=59, TIME_W=6 and the default CLK_FREQ; the minutes and hours blocks use the same package.
REQ-025 The prescaler is a separate sub-module sec_prescaler (ports: clk, rst, enable, strobe), reusable by the stopwatch.
REQ-026 seconds contains one registered always block for state and one combinational next-state block; done_second is a flop, not a gate.

Verification (CLK_FREQ=4)
REQ-027 rst 2 cycles, display=0, run 8 cycles -> second 0,0,0,0,1,1,1,1,2 pattern; first increment on the 4th edge after release.
REQ-028 Force second=59 via setup, return to run -> after 4 cycles second=0 and done_second=1 for exactly 1 cycle; minutes block increments once.
REQ-029 display=1, setup_second=0, inc_dec_sec=0, tick pulse at second=0 -> second=59, done_second stays 0.
REQ-030 display=1, setup_second=1, 5 tick pulses -> second unchanged; then display=0 with tick held 1 -> tick ignored.
REQ-031 Assert rst at prescaler count 2 with second=37 -> next edge second=0, done_second=0; first increment 4 cycles after release.
REQ-032 Toggle display 0->1 in the strobe cycle -> no increment; back to 0 -> increment after exactly 4 cycles.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared timekeeping definitions for the seconds, minutes and hours blocks.
package clock_pkg;

  localparam int              TIME_W           = 6;
  localparam logic [5:0]      SEC_MAX          = 6'd59;
  localparam int unsigned     CLK_FREQ_DEFAULT = 32'd50_000_000;

  // Operating mode as carried on the display input.
  typedef enum logic {
    MODE_RUN   = 1'b0,
    MODE_SETUP = 1'b1
  } mode_e;

  // Step up with wrap; anything at or above max_v (including corrupt values) lands on 0.
  function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] v,
                                                 input logic [TIME_W-1:0] max_v);
    logic [TIME_W-1:0] r;
    if (v >= max_v) begin
      r = {TIME_W{1'b0}};
    end else begin
      r = v + TIME_W'(1);
    end
    return r;
  endfunction

  // Step down with wrap; 0 goes to max_v, corrupt values above max_v land on 0.
  function automatic logic [TIME_W-1:0] wrap_dec(input logic [TIME_W-1:0] v,
                                                 input logic [TIME_W-1:0] max_v);
    logic [TIME_W-1:0] r;
    if (v > max_v) begin
      r = {TIME_W{1'b0}};
    end else if (v == {TIME_W{1'b0}}) begin
      r = max_v;
    end else begin
      r = v - TIME_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides clk down to a one-cycle strobe every CLK_FREQ cycles while enabled.
// Held at zero while disabled so the first strobe after enable is a full period away.
module sec_prescaler
  import clock_pkg::*;
#(
  parameter int unsigned CLK_FREQ = CLK_FREQ_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic strobe
);

  localparam int unsigned       CNT_W   = (CLK_FREQ > 32'd1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLK_FREQ - 32'd1);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;

  // Next count: clear when disabled, wrap at the terminal count, else advance.
  always_comb begin
    count_nxt_s = count_r;
    if (!enable) begin
      count_nxt_s = {CNT_W{1'b0}};
    end else if (count_r == CNT_MAX) begin
      count_nxt_s = {CNT_W{1'b0}};
    end else begin
      count_nxt_s = count_r + CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign strobe = (count_r == CNT_MAX);

endmodule

// File: rtl/seconds.sv
// Seconds counter: advances once per second in run mode, hand-edited in setup
// mode, and emits a registered carry pulse to the minutes block on 59 -> 0.
module seconds
  import clock_pkg::*;
#(
  parameter int unsigned CLK_FREQ = CLK_FREQ_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              display,
  input  logic              setup_second,
  input  logic              inc_dec_sec,
  input  logic              tick,
  output logic [TIME_W-1:0] second,
  output logic              done_second
);

  logic              sec_strobe_s;
  logic              run_en_s;
  mode_e             mode_s;
  logic [TIME_W-1:0] second_r;
  logic [TIME_W-1:0] second_nxt_s;
  logic              done_r;
  logic              done_nxt_s;

  assign mode_s   = mode_e'(display);
  assign run_en_s = (mode_s == MODE_RUN);

  sec_prescaler #(
    .CLK_FREQ (CLK_FREQ)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (run_en_s),
    .strobe (sec_strobe_s)
  );

  // Next-state: timekeeping in run mode, tick-driven edits in setup mode.
  always_comb begin
    second_nxt_s = second_r;
    done_nxt_s   = 1'b0;
    case (mode_s)
      MODE_RUN: begin
        if (sec_strobe_s) begin
          if (second_r == SEC_MAX) begin
            second_nxt_s = {TIME_W{1'b0}};
            done_nxt_s   = 1'b1;
          end else begin
            second_nxt_s = wrap_inc(second_r, SEC_MAX);
          end
        end else begin
          second_nxt_s = second_r;
        end
      end
      MODE_SETUP: begin
        if (!setup_second && tick) begin
          if (inc_dec_sec) begin
            second_nxt_s = wrap_inc(second_r, SEC_MAX);
          end else begin
            second_nxt_s = wrap_dec(second_r, SEC_MAX);
          end
        end else begin
          second_nxt_s = second_r;
        end
      end
      default: begin
        second_nxt_s = second_r;
        done_nxt_s   = 1'b0;
      end
    endcase
  end

  // State register: seconds value and the carry pulse flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      second_r <= {TIME_W{1'b0}};
      done_r   <= 1'b0;
    end else begin
      second_r <= second_nxt_s;
      done_r   <= done_nxt_s;
    end
  end

  assign second      = second_r;
  assign done_second = done_r;

endmodule
